pipelined_adder: RTL and testbench



---
 rtl/pipelined_adder.sv | 147 ++++++++++++++
 tb/tb_pipelined_adder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
`timescale 1ns/1ps
// Purpose : pipelined WIDTH-bit add/subtract, one CW=WIDTH/STAGES chunk resolved per stage.
// Latency : STAGES cycles from the accepting edge to S/CarryOut/out_valid; one op per cycle.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready combinationally.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready          operand handshake (A, B, CarryIn, Sub)
//   A, B                       operands; Sub=0: A+B+CarryIn, Sub=1: A-B (CarryIn ignored)
//   out_valid/out_ready        result handshake (S, CarryOut[, Zero, Overflow])
//   S, CarryOut                registered result; CarryOut=1 on Sub means no borrow
//   Zero, Overflow             only when PIPE_ADDER_FLAGS_EN is defined
//
// Optional feature macro: PIPE_ADDER_FLAGS_EN (registered Zero / signed Overflow flags).
//
// Structure: slot 0 is an entry register holding A, Beff and the stage-0 carry-in.
// Slot k (1..STAGES) holds the result of adding chunk k-1, so slot STAGES is the
// output register. Operands travel alongside their partial sum until consumed.

module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CarryIn,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             CarryOut
`ifdef PIPE_ADDER_FLAGS_EN
    ,
    output logic             Zero,
    output logic             Overflow
`endif
);

    localparam int CW  = WIDTH / STAGES;
    localparam int MSB = WIDTH - 1;

    if ((WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_adder: STAGES must divide WIDTH exactly");
    end

    // Global advance: the pipe moves only when the output slot is empty or drained.
    logic adv;

    logic [STAGES:0]  vld_q, vld_d;
    logic [STAGES:0]  cy_q,  cy_d;
    logic [WIDTH-1:0] sum_q [0:STAGES];
    logic [WIDTH-1:0] sum_d [0:STAGES];
    logic [WIDTH-1:0] a_q   [0:STAGES-1];
    logic [WIDTH-1:0] a_d   [0:STAGES-1];
    logic [WIDTH-1:0] b_q   [0:STAGES-1];
    logic [WIDTH-1:0] b_d   [0:STAGES-1];
    logic [CW:0]      part  [1:STAGES];

    always_comb begin
        adv = !vld_q[STAGES] || out_ready;

        // Entry slot. Bubbles load zeros so S/CarryOut stay deterministic.
        vld_d[0] = in_valid;
        a_d[0]   = in_valid ? A : '0;
        b_d[0]   = in_valid ? (Sub ? ~B : B) : '0;
        cy_d[0]  = in_valid && (Sub || CarryIn);
        sum_d[0] = '0;

        // Slot k finishes chunk k-1 using the carry rippled out of slot k-1.
        for (int k = 1; k <= STAGES; k++) begin
            part[k]  = {1'b0, a_q[k-1][(k-1)*CW +: CW]}
                     + {1'b0, b_q[k-1][(k-1)*CW +: CW]}
                     + {{CW{1'b0}}, cy_q[k-1]};
            vld_d[k] = vld_q[k-1];
            cy_d[k]  = part[k][CW];
            sum_d[k] = sum_q[k-1];
            sum_d[k][(k-1)*CW +: CW] = part[k][CW-1:0];
        end

        // Operands ride along to every slot that still has a chunk to consume.
        for (int k = 1; k < STAGES; k++) begin
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            cy_q  <= '0;
            for (int k = 0; k <= STAGES; k++) begin
                sum_q[k] <= '0;
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            for (int k = 0; k <= STAGES; k++) begin
                sum_q[k] <= sum_d[k];
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
            end
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES];
    assign S         = sum_q[STAGES];
    assign CarryOut  = cy_q[STAGES];

`ifdef PIPE_ADDER_FLAGS_EN
    // Flags are formed as the final chunk lands so they align with S.
    // The last slot still carries A and Beff, whose MSBs decide signed overflow.
    logic zero_q, zero_d;
    logic ovf_q,  ovf_d;

    always_comb begin
        zero_d = vld_q[STAGES-1] && (sum_d[STAGES] == '0);
        ovf_d  = vld_q[STAGES-1]
              && (a_q[STAGES-1][MSB] == b_q[STAGES-1][MSB])
              && (sum_d[STAGES][MSB] != a_q[STAGES-1][MSB]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv) begin
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign Zero     = zero_q;
    assign Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
`timescale 1ns/1ps
// Purpose : scoreboard bench for pipelined_adder (WIDTH=32, STAGES=4).
// Latency : driver pushes expected results on accept; monitor pops on each output transfer.
// Backpressure: bench drives out_ready, including a multi-cycle stall.

module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_in, b_in;
    logic        cin, sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s_out;
    logic        cout;
`ifdef PIPE_ADDER_FLAGS_EN
    logic        zero_out, ovf_out;
`endif

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a_in),
        .B         (b_in),
        .CarryIn   (cin),
        .Sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (s_out),
`ifdef PIPE_ADDER_FLAGS_EN
        .Zero      (zero_out),
        .Overflow  (ovf_out),
`endif
        .CarryOut  (cout)
    );

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        z;
        logic        o;
        int          acc;
        int          st;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   stall_cnt = 0;
    int   emitted   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
        end
    endtask

    // Monitor: samples 2 time units after the falling edge, after the driver settles.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (out_valid && out_ready) begin
                    emitted++;
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output actual S=0x%08h required no result", s_out);
                    end else begin
                        e = q.pop_front();
                        chk("S", s_out, e.s);
                        chk("CarryOut", {31'b0, cout}, {31'b0, e.c});
`ifdef PIPE_ADDER_FLAGS_EN
                        chk("Zero", {31'b0, zero_out}, {31'b0, e.z});
                        chk("Overflow", {31'b0, ovf_out}, {31'b0, e.o});
`endif
                        if (e.st == stall_cnt)
                            chk("latency", cyc - e.acc, 32'd4);
                    end
                end
                if (out_valid && !out_ready) stall_cnt++;
            end
        end
    end

    // Drive one operation; push its expectation once in_ready guarantees acceptance.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb,
                         input logic [31:0] es, input logic ec, input logic ez, input logic eo);
        int   n;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        cin      = ci;
        sub      = sb;
        #1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'd0, 32'd1);
        end else begin
            e.s   = es;
            e.c   = ec;
            e.z   = ez;
            e.o   = eo;
            e.acc = cyc + 1;
            e.st  = stall_cnt;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(nm, q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        int          base;

        reset     = 1'b1;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_S", s_out, 32'd0);
        chk("rst_CarryOut", {31'b0, cout}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef PIPE_ADDER_FLAGS_EN
        chk("rst_Zero", {31'b0, zero_out}, 32'd0);
        chk("rst_Overflow", {31'b0, ovf_out}, 32'd0);
`endif

        // Directed vectors:      A             B             Cin   Sub   S             C     Z     O
        issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0);
        idle(1);
        drain("drain_single");
        issue(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        issue(32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0);
        issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1);
        issue(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1);
        issue(32'h12345678, 32'h0FEDCBA9, 1'b1, 1'b0, 32'h22222222, 1'b0, 1'b0, 1'b0);
        issue(32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        issue(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1);
        issue(32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0);
        issue(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
        idle(1);
        drain("drain_directed");

        // Back-to-back stream: S = 0x11*i + i[0].
        for (int i = 0; i < 8; i++) begin
            logic [31:0] iv;
            iv = i;
            issue(iv, iv * 32'h10, iv[0], 1'b0, iv * 32'h11 + {31'b0, iv[0]}, 1'b0, (i == 0), 1'b0);
        end
        idle(1);
        drain("drain_stream");

        // Fill the pipe, then stall the output for three cycles.
        base = emitted;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] iv;
            iv = i;
            issue(32'hA0000000 + iv, 32'h0F0000F0, 1'b0, 1'b0, 32'hAF0000F0 + iv, 1'b0, 1'b0, 1'b0);
        end
        idle(1);
        begin
            int n = 0;
            #1;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        chk("stall_out_valid_seen", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b0;
        held      = s_out;
        repeat (3) begin
            #0;
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            chk("stall_S_hold", s_out, held);
            chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain("drain_stall");
        repeat (3) @(negedge clk);
        chk("stall_emit_count", emitted - base, 32'd4);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            logic [31:0] iv;
            iv = i;
            issue(32'h00000100 + iv, 32'h00000001, 1'b0, 1'b0, 32'h00000101 + iv, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            #1;
            chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
            chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
            @(negedge clk);
        end
        base = emitted;
        issue(32'h00000123, 32'h00000456, 1'b0, 1'b0, 32'h00000579, 1'b0, 1'b0, 1'b0);
        idle(1);
        drain("drain_after_reset");
        repeat (6) @(negedge clk);
        chk("post_reset_emit_count", emitted - base, 32'd1);
        chk("queue_empty_end", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
